// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and fetch constants.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// DEPTH-entry FIFO holding {pc, instruction}; head is read combinationally from registered storage.
module instruction_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order imem reads under a credit limit, buffers responses.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall / perf_bubble counters.
//
// state   | meaning
// S_BOOT  | one idle cycle after reset release
// S_RUN   | issuing fetches and accepting responses into the FIFO
// S_DRAIN | redirect taken with fetches in flight; stale responses are dropped
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_bubble
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     out_nxt;
  logic [ADDR_W-1:0] pcq [DEPTH];
  logic [PW-1:0]     pq_wr;
  logic [PW-1:0]     pq_rd;
  logic [ADDR_W-1:0] redirect_aligned;

  logic              accept;
  logic              rsp_ok;
  logic              credit_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W+31:0] fifo_head;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Outstanding plus buffered never exceeds DEPTH, so responses never need back-pressure.
  assign credit_ok = !fifo_full && (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C);
  assign imem_req  = (state == S_RUN) && !redirect_valid && credit_ok;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign rsp_ok    = imem_rvalid && (outstanding != '0);
  assign out_nxt   = outstanding + CW'(accept) - CW'(rsp_ok);

  assign fifo_push = rsp_ok && (state == S_RUN) && !redirect_valid;
  assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid  = !fifo_empty;
  assign instruction = inst_valid ? fifo_head[31:0] : NOP_INSTR;
  assign inst_pc     = inst_valid ? fifo_head[ADDR_W+31:32] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   if (redirect_valid && (out_nxt != '0)) state_nxt = S_DRAIN;
      S_DRAIN: if (out_nxt == '0) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (accept) pq_wr <= pq_wr + 1'b1;
      if (rsp_ok) pq_rd <= pq_rd + 1'b1;
      if (redirect_valid)  pc <= redirect_aligned;
      else if (accept)     pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  // PC of each in-flight request, consumed in order as responses return (dropped or not).
  always_ff @(posedge clock) begin
    if (accept) pcq[pq_wr] <= pc;
  end

  instruction_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + 32)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect_valid),
    .wdata   ({pcq[pq_rd], imem_rdata}),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_bubble  <= '0;
    end else begin
      if (fifo_pop)                        perf_fetched <= perf_fetched + 32'd1;
      if (inst_valid && !inst_ready)       perf_stall   <= perf_stall + 32'd1;
      if (!inst_valid && (state == S_RUN)) perf_bubble  <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule
